health_ctrl: RTL and testbench
==============================

# health_ctrl

Health controller for the player. It captures damage pulses from up to N_SRC enemy/hazard sources and round-robin arbitrates them. It applies damage and heal to a saturating health register, enforces a deterministic invulnerability window after each hit, and signals death and revive. It sits between the collision/enemy logic and the HUD/game-state logic, and owns the only copy of player health.

## Interface
- N_SRC, 4, number of damage sources (1..8)
- MAX_HEALTH, 8, reset/revive health value (1..15)
- IFRAME_TICKS, 16, invulnerability length in ticks (1..255)
- TICK_DIV, 6000000, clk cycles per tick (≥2; benches use small values)
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; low at a rising edge resets the whole block
- dmg_req  in  N_SRC  per-source damage strobe, one-cycle pulse
- dmg_amt  in  2*N_SRC  per-source amount, source i at [2i+1:2i], valid with dmg_req[i]
- heal_req  in  1  heal request level; held until heal_ack
- heal_amt  in  2  heal amount, stable while heal_req high
- revive  in  1  revive strobe; honoured only in DEAD
- dmg_ack  out  N_SRC  one-cycle pulse: pending hit of source i consumed (applied or discarded)
- heal_ack  out  1  one-cycle pulse: heal applied
- health  out  4  current health
- invuln  out  1  high in state INVULN
- dead  out  1  high in state DEAD
- hit_pulse  out  1  one-cycle pulse when damage is actually applied

## Operation
- Reset values: health=MAX_HEALTH, state=IDLE, invuln=0, dead=0, all acks/hit_pulse=0, pending=0, amounts=0, rr pointer=0, tick divider=0, iframe counter=0.
- Capture: dmg_req[i]=1 with amt≠0 sets pending[i]. amt_q[i]=max(amt_q[i], new) if already pending, else new. amt=0 is ignored. A pulse arriving in the same cycle as that source's ack re-arms pending with the new amount.
- States: IDLE, INVULN, DEAD.
- IDLE:
  - If any pending, grant one source by round-robin. The search starts at rr pointer; the pointer moves to grant+1 mod N_SRC.
  - Clear its pending and pulse dmg_ack[grant] and hit_pulse.
  - health ← health − amt, saturating at 0.
  - Result 0 → DEAD. Otherwise → INVULN, load the iframe counter with IFRAME_TICKS and clear the tick divider.
  - If no pending and heal_req: health ← min(health + heal_amt, MAX_HEALTH), pulse heal_ack. Damage has priority, so a heal is not acked in a cycle that grants damage.
- INVULN:
  - Every pending source is cleared with dmg_ack in the same cycle; no damage, no hit_pulse.
  - Heal is served as in IDLE.
  - On each tick the iframe counter decrements. The tick that makes it 0 → IDLE.
- DEAD:
  - health=0. Pending damage is acked and discarded. heal_req is never acked.
  - revive → health=MAX_HEALTH, INVULN with a full window (spawn protection), divider cleared.
- Tick divider: free-running 0..TICK_DIV−1; tick=1 when count=TICK_DIV−1.
- Width rules: the health arithmetic uses 5 bits internally before saturation. MAX_HEALTH ≤ 15 is enforced by an elaboration check.

## Timing
- A request pulse sampled at edge t is pending after edge t. It is granted at edge t+1: health, dmg_ack, hit_pulse and invuln are visible after t+1. Latency is 2 edges when idle.
- Back-to-back sources: the second hit is discarded during INVULN, never deferred past it.
- INVULN lasts exactly IFRAME_TICKS*TICK_DIV cycles from the hit edge to the return to IDLE.
- heal_req high at edge t in IDLE/INVULN with no damage grant → heal_ack and the new health after edge t.
- reset low mid-window or mid-death → reset values at that edge regardless of other inputs.
- All outputs are registered; no combinational input→output paths.

## Structure
- Shared package health_pkg: state enum (IDLE/INVULN/DEAD), default constants for MAX_HEALTH, IFRAME_TICKS, TICK_DIV, and the 2-bit amount type.
- One sub-module: rr_arbiter (N-wide request vector, pointer in, one-hot grant and grant index out, combinational).
- Capture registers, divider, iframe counter and FSM live in health_ctrl.

## Test plan
Bench setup: N_SRC=4, MAX_HEALTH=8, IFRAME_TICKS=3, TICK_DIV=4.
- Reset and a single hit: reset, then dmg_req[2] with amt=3. Health goes 8→5 two edges later, dmg_ack[2] and hit_pulse pulse once, invuln is high for exactly 12 cycles, then IDLE.
- Simultaneous hits: dmg_req=4'b1011 with amts 1,2,–,1 in one cycle, pointer=0. Source 0 is applied (8→7). Sources 1 and 3 are acked and discarded during INVULN, and health stays 7.
- Round-robin fairness: after a grant to source 0, sources 0 and 1 pulse together once IDLE. Source 1 is granted.
- Saturation and death: health=2, hit amt=3 → health=0, dead=1. A further heal_req is never acked. revive → health=8, invuln for 12 cycles, dead=0.
- Heal versus damage: health=7 in IDLE, heal_req amt=3 and dmg pending at the same edge. Damage is applied first (7→6, INVULN). The heal is acked the next cycle, giving health=8 (saturated at MAX).
- Reset mid-window: assert reset low 5 cycles into INVULN. All outputs return to reset values at that edge, and pending/acks are cleared.

Source files
------------

// File: rtl/health_pkg.sv
// Shared types and default constants for the player health controller.
package health_pkg;

    // Controller modes
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    // Per-hit / per-heal amount
    typedef logic [1:0] amt_t;

    localparam int HEALTH_W         = 4;
    localparam int DEF_MAX_HEALTH   = 8;
    localparam int DEF_IFRAME_TICKS = 16;
    localparam int DEF_TICK_DIV     = 6000000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    // First requester at or after ptr wins
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_any && req[idx]) begin
                gnt_any      = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/health_ctrl.sv
// Player health controller: captures damage pulses, arbitrates them
// round-robin, applies damage/heal with saturation, and runs the
// invulnerability window and death/revive sequencing.
module health_ctrl
    import health_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int MAX_HEALTH   = DEF_MAX_HEALTH,
    parameter int IFRAME_TICKS = DEF_IFRAME_TICKS,
    parameter int TICK_DIV     = DEF_TICK_DIV
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_SRC-1:0]      dmg_req,
    input  logic [2*N_SRC-1:0]    dmg_amt,
    input  logic                  heal_req,
    input  logic [1:0]            heal_amt,
    input  logic                  revive,
    output logic [N_SRC-1:0]      dmg_ack,
    output logic                  heal_ack,
    output logic [HEALTH_W-1:0]   health,
    output logic                  invuln,
    output logic                  dead,
    output logic                  hit_pulse
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    if (MAX_HEALTH < 1 || MAX_HEALTH > 15) begin : g_bad_max_health
        $error("health_ctrl: MAX_HEALTH must be in 1..15");
    end
    if (N_SRC < 1 || N_SRC > 8) begin : g_bad_n_src
        $error("health_ctrl: N_SRC must be in 1..8");
    end

    function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] h, input amt_t a);
        logic signed [HEALTH_W:0] d;
        d = $signed({1'b0, h}) - $signed({3'b000, a});
        return (d < 0) ? '0 : d[HEALTH_W-1:0];
    endfunction

    function automatic logic [HEALTH_W-1:0] sat_add(input logic [HEALTH_W-1:0] h, input amt_t a);
        logic [HEALTH_W:0] s;
        s = {1'b0, h} + {3'b000, a};
        return (s > 5'(MAX_HEALTH)) ? HEALTH_W'(MAX_HEALTH) : s[HEALTH_W-1:0];
    endfunction

    state_t              state_q, state_d;
    logic [N_SRC-1:0]    pend_q;
    amt_t                amt_q [N_SRC];
    logic [IW-1:0]       rr_q, rr_d;
    logic [DW-1:0]       div_q, div_d;
    logic [7:0]          ifr_q, ifr_d;
    logic [HEALTH_W-1:0] health_d;
    logic [N_SRC-1:0]    clr;
    logic                hit_d, heal_ack_d, tick;
    logic [N_SRC-1:0]    gnt;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_any;

    rr_arbiter #(.N(N_SRC), .IW(IW)) u_arb (
        .req     (pend_q),
        .ptr     (rr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign tick = (div_q == DIV_LAST);

    // Next-state, health update and consumed-hit vector
    always_comb begin
        state_d    = state_q;
        health_d   = health;
        clr        = '0;
        hit_d      = 1'b0;
        heal_ack_d = 1'b0;
        rr_d       = rr_q;
        ifr_d      = ifr_q;
        div_d      = tick ? '0 : div_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    clr      = gnt;
                    hit_d    = 1'b1;
                    health_d = sat_sub(health, amt_q[gnt_idx]);
                    rr_d     = (gnt_idx == IW'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
                    if (health_d == '0) begin
                        state_d = DEAD;
                    end else begin
                        state_d = INVULN;
                        ifr_d   = 8'(IFRAME_TICKS);
                        div_d   = '0;
                    end
                end else if (heal_req) begin
                    health_d   = sat_add(health, heal_amt);
                    heal_ack_d = 1'b1;
                end
            end
            INVULN: begin
                clr = pend_q;
                if (heal_req) begin
                    health_d   = sat_add(health, heal_amt);
                    heal_ack_d = 1'b1;
                end
                if (tick) begin
                    ifr_d = ifr_q - 8'd1;
                    if (ifr_q == 8'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            DEAD: begin
                clr      = pend_q;
                health_d = '0;
                if (revive) begin
                    health_d = HEALTH_W'(MAX_HEALTH);
                    state_d  = INVULN;
                    ifr_d    = 8'(IFRAME_TICKS);
                    div_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            health    <= HEALTH_W'(MAX_HEALTH);
            rr_q      <= '0;
            div_q     <= '0;
            ifr_q     <= '0;
            dmg_ack   <= '0;
            heal_ack  <= 1'b0;
            hit_pulse <= 1'b0;
            invuln    <= 1'b0;
            dead      <= 1'b0;
        end else begin
            state_q   <= state_d;
            health    <= health_d;
            rr_q      <= rr_d;
            div_q     <= div_d;
            ifr_q     <= ifr_d;
            dmg_ack   <= clr;
            heal_ack  <= heal_ack_d;
            hit_pulse <= hit_d;
            invuln    <= (state_d == INVULN);
            dead      <= (state_d == DEAD);
        end
    end

    // Hit capture: a new nonzero pulse re-arms even while being consumed
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_q <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                amt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (dmg_req[i] && (dmg_amt[2*i +: 2] != 2'd0)) begin
                    pend_q[i] <= 1'b1;
                    if (pend_q[i] && !clr[i] && (amt_q[i] > dmg_amt[2*i +: 2])) begin
                        amt_q[i] <= amt_q[i];
                    end else begin
                        amt_q[i] <= dmg_amt[2*i +: 2];
                    end
                end else if (clr[i]) begin
                    pend_q[i] <= 1'b0;
                    amt_q[i]  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_health_ctrl.sv
// Self-checking bench for health_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_health_ctrl;

    localparam int N    = 4;
    localparam int MAXH = 8;
    localparam int IFR  = 3;
    localparam int TDIV = 4;
    localparam int WIN  = IFR * TDIV;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   dmg_req = '0;
    logic [2*N-1:0] dmg_amt = '0;
    logic           heal_req = 1'b0;
    logic [1:0]     heal_amt = '0;
    logic           revive = 1'b0;
    logic [N-1:0]   dmg_ack;
    logic           heal_ack;
    logic [3:0]     health;
    logic           invuln;
    logic           dead;
    logic           hit_pulse;

    always #5 clk = ~clk;

    health_ctrl #(
        .N_SRC(N), .MAX_HEALTH(MAXH), .IFRAME_TICKS(IFR), .TICK_DIV(TDIV)
    ) dut (
        .clk(clk), .reset(reset), .dmg_req(dmg_req), .dmg_amt(dmg_amt),
        .heal_req(heal_req), .heal_amt(heal_amt), .revive(revive),
        .dmg_ack(dmg_ack), .heal_ack(heal_ack), .health(health),
        .invuln(invuln), .dead(dead), .hit_pulse(hit_pulse)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Behavioural model: mode 0=idle 1=invulnerable 2=dead, window in cycles
    int       m_health, m_mode, m_win, m_rr;
    bit [N-1:0] m_pend;
    int       m_amt [N];
    bit [N-1:0] m_ack;
    bit       m_hack, m_hit;

    task automatic model_step();
        bit [N-1:0] clr;
        int g;
        clr = '0; m_hack = 0; m_hit = 0; g = -1;
        if (!reset) begin
            m_health = MAXH; m_mode = 0; m_win = 0; m_rr = 0; m_pend = '0;
            for (int i = 0; i < N; i++) m_amt[i] = 0;
            m_ack = '0;
            return;
        end
        case (m_mode)
            0: begin
                if (m_pend != '0) begin
                    for (int k = 0; k < N; k++)
                        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
                    clr[g] = 1'b1;
                    m_hit = 1;
                    m_health = (m_health > m_amt[g]) ? m_health - m_amt[g] : 0;
                    m_rr = (g + 1) % N;
                    if (m_health == 0) m_mode = 2;
                    else begin m_mode = 1; m_win = WIN; end
                end else if (heal_req) begin
                    m_health = (m_health + int'(heal_amt) > MAXH) ? MAXH : m_health + int'(heal_amt);
                    m_hack = 1;
                end
            end
            1: begin
                clr = m_pend;
                if (heal_req) begin
                    m_health = (m_health + int'(heal_amt) > MAXH) ? MAXH : m_health + int'(heal_amt);
                    m_hack = 1;
                end
                m_win--;
                if (m_win == 0) m_mode = 0;
            end
            default: begin
                clr = m_pend;
                m_health = 0;
                if (revive) begin m_health = MAXH; m_mode = 1; m_win = WIN; end
            end
        endcase
        for (int i = 0; i < N; i++) begin
            int a;
            a = int'(dmg_amt[2*i +: 2]);
            if (dmg_req[i] && a != 0) begin
                if (!(m_pend[i] && !clr[i] && m_amt[i] > a)) m_amt[i] = a;
                m_pend[i] = 1'b1;
            end else if (clr[i]) begin
                m_pend[i] = 1'b0;
            end
        end
        m_ack = clr;
    endtask

    // One clock: advance model at the edge, compare outputs 1ns later
    task automatic step(input string tag);
        logic [11:0] got, exp;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        got = {health, invuln, dead, dmg_ack, heal_ack, hit_pulse};
        exp = {4'(m_health), m_mode == 1, m_mode == 2, m_ack, m_hack, m_hit};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL model_%s cyc=%0d got h=%0d inv=%0b dead=%0b ack=%b hack=%b hit=%b expected h=%0d inv=%0b dead=%0b ack=%b hack=%b hit=%b",
                     tag, cyc, got[11:8], got[7], got[6], got[5:2], got[1], got[0],
                     exp[11:8], exp[7], exp[6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        reset = 1'b1; dmg_req = '0; dmg_amt = '0; heal_req = 1'b0; heal_amt = '0; revive = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (invuln && n < 40) begin step(tag); n++; end
        if (invuln) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: invuln still 1 after %0d cycles, expected 0", tag, n);
        end
    endtask

    task automatic hit(input int src, input int amt);
        dmg_req = '0; dmg_req[src] = 1'b1;
        dmg_amt = '0; dmg_amt[2*src +: 2] = 2'(amt);
        step("hit_cap");
        clear_inputs();
        step("hit_app");
    endtask

    typedef struct {
        logic rst; logic [3:0] dreq; logic [7:0] damt; logic hreq; logic [1:0] hamt; logic rev;
        logic [3:0] eh; logic einv; logic edead; logic [3:0] eack; logic ehack; logic ehit;
    } vec_t;
    vec_t vq[$];

    function automatic void push(input logic rst, input logic [3:0] dreq, input logic [7:0] damt,
                                 input logic [3:0] eh, input logic einv, input logic [3:0] eack,
                                 input logic ehit);
        vec_t v;
        v.rst = rst; v.dreq = dreq; v.damt = damt; v.hreq = 1'b0; v.hamt = 2'd0; v.rev = 1'b0;
        v.eh = eh; v.einv = einv; v.edead = 1'b0; v.eack = eack; v.ehack = 1'b0; v.ehit = ehit;
        vq.push_back(v);
    endfunction

    initial begin
        int cnt;
        // Reset, single hit from source 2 and its 12-cycle window
        push(0, 4'b0000, 8'h00, 8, 0, 4'b0000, 0);
        push(0, 4'b0000, 8'h00, 8, 0, 4'b0000, 0);
        push(1, 4'b0100, 8'h30, 8, 0, 4'b0000, 0);
        push(1, 4'b0000, 8'h00, 5, 1, 4'b0100, 1);
        for (int k = 0; k < WIN - 1; k++) push(1, 4'b0000, 8'h00, 5, 1, 4'b0000, 0);
        push(1, 4'b0000, 8'h00, 5, 0, 4'b0000, 0);
        // Re-reset for pointer 0, then simultaneous hits 0,1,3
        push(0, 4'b0000, 8'h00, 8, 0, 4'b0000, 0);
        push(1, 4'b1011, 8'h49, 8, 0, 4'b0000, 0);
        push(1, 4'b0000, 8'h00, 7, 1, 4'b0001, 1);
        push(1, 4'b0000, 8'h00, 7, 1, 4'b1010, 0);
        for (int k = 0; k < WIN - 2; k++) push(1, 4'b0000, 8'h00, 7, 1, 4'b0000, 0);
        push(1, 4'b0000, 8'h00, 7, 0, 4'b0000, 0);
        // Round robin: pointer now 1, sources 0 and 1 together
        push(1, 4'b0011, 8'h05, 7, 0, 4'b0000, 0);
        push(1, 4'b0000, 8'h00, 6, 1, 4'b0010, 1);
        push(1, 4'b0000, 8'h00, 6, 1, 4'b0001, 0);
        for (int k = 0; k < WIN - 2; k++) push(1, 4'b0000, 8'h00, 6, 1, 4'b0000, 0);
        push(1, 4'b0000, 8'h00, 6, 0, 4'b0000, 0);

        for (int k = 0; k < vq.size(); k++) begin
            logic [11:0] got, exp;
            reset = vq[k].rst; dmg_req = vq[k].dreq; dmg_amt = vq[k].damt;
            heal_req = vq[k].hreq; heal_amt = vq[k].hamt; revive = vq[k].rev;
            step("tbl");
            got = {health, invuln, dead, dmg_ack, heal_ack, hit_pulse};
            exp = {vq[k].eh, vq[k].einv, vq[k].edead, vq[k].eack, vq[k].ehack, vq[k].ehit};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL vec%0d got %b expected %b", k, got, exp);
            end
        end
        clear_inputs();

        // Saturation and death: bring health to 2, then hit for 3
        hit(0, 3); wait_idle("w1");
        hit(0, 1); wait_idle("w2");
        chk("pre_death_health", health, 2);
        hit(1, 3);
        chk("death_health", health, 0);
        chk("death_dead", dead, 1);
        chk("death_invuln", invuln, 0);
        heal_req = 1'b1; heal_amt = 2'd2;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin step("dead_heal"); if (heal_ack) cnt++; end
        chk("dead_heal_acks", cnt, 0);
        chk("dead_heal_health", health, 0);
        heal_req = 1'b0;
        step("dead_idle");
        revive = 1'b1; step("revive"); revive = 1'b0;
        chk("revive_health", health, MAXH);
        chk("revive_dead", dead, 0);
        cnt = invuln ? 1 : 0;
        for (int k = 0; k < 40 && invuln; k++) begin step("rev_win"); if (invuln) cnt++; end
        chk("revive_window", cnt, WIN);

        // Heal versus damage at the same edge
        hit(2, 1); wait_idle("w3");
        chk("pre_heal_health", health, 7);
        dmg_req = 4'b1000; dmg_amt = 8'h40;
        step("hd_cap");
        dmg_req = '0; dmg_amt = '0; heal_req = 1'b1; heal_amt = 2'd3;
        step("hd_grant");
        chk("hd_dmg_health", health, 6);
        chk("hd_dmg_hit", hit_pulse, 1);
        chk("hd_no_heal_ack", heal_ack, 0);
        step("hd_heal");
        chk("hd_heal_ack", heal_ack, 1);
        chk("hd_heal_health", health, MAXH);
        heal_req = 1'b0;
        wait_idle("w4");

        // Reset five cycles into the window, with every input active
        hit(0, 2);
        for (int k = 0; k < 4; k++) step("mid_win");
        chk("mid_win_invuln", invuln, 1);
        reset = 1'b0; dmg_req = 4'b1111; dmg_amt = 8'hFF; heal_req = 1'b1; heal_amt = 2'd3; revive = 1'b1;
        step("mid_rst");
        chk("rst_health", health, MAXH);
        chk("rst_invuln", invuln, 0);
        chk("rst_dead", dead, 0);
        chk("rst_ack", int'(dmg_ack), 0);
        chk("rst_heal_ack", heal_ack, 0);
        chk("rst_hit", hit_pulse, 0);
        clear_inputs();
        step("post_rst");
        chk("post_rst_ack", int'(dmg_ack), 0);
        chk("post_rst_hit", hit_pulse, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            dmg_req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
            dmg_amt = 8'($urandom);
            if (!heal_req && $urandom_range(0, 7) == 0) begin
                heal_req = 1'b1; heal_amt = 2'($urandom);
            end
            revive = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 399) != 0);
            step("rnd");
            if (heal_ack) heal_req = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
